// File: rtl/palette_engine_if.sv
// palette_engine_if
//   CPU-side palette bus for palette_engine.
//   master : CPU / register block (drives writes and readback requests)
//   slave  : palette_engine (returns readback data)
//   Signals:
//     pal_we     palette write strobe
//     pal_waddr  palette write address {select, index}
//     pal_wdata  palette write data {R,G,B}
//     pal_raddr  readback address
//     pal_rd     readback strobe
//     pal_rdata  readback data {R,G,B}
//     pal_rvalid readback data valid
interface palette_engine_if #(
  parameter int SEL_W   = 5,
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 4
);
  logic                         pal_we;
  logic [SEL_W+IDX_W-1:0]       pal_waddr;
  logic [3*COLOR_W-1:0]         pal_wdata;
  logic [SEL_W+IDX_W-1:0]       pal_raddr;
  logic                         pal_rd;
  logic [3*COLOR_W-1:0]         pal_rdata;
  logic                         pal_rvalid;

  modport master (
    output pal_we, pal_waddr, pal_wdata, pal_raddr, pal_rd,
    input  pal_rdata, pal_rvalid
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, pal_raddr, pal_rd,
    output pal_rdata, pal_rvalid
  );
endinterface

// File: rtl/palette_engine.sv
// palette_engine
//   Pipelined palette lookup between frame-buffer read and HDMI encoder.
//   Pixel codes {select, index} index a CPU-writable palette RAM; a game
//   window shows palette colours, a text region to its left shows a fixed
//   foreground colour wherever the font row bit is set. A frame-synchronous
//   FSM fades the output in/out in 16 levels. Fixed latency of 2 cycles.
//
//   Optional feature macro: PALETTE_READBACK_EN (second RAM read port for
//   CPU readback; without it pal_rdata/pal_rvalid are tied to 0).
//
//   Ports:
//     axi_aclk     clock
//     axi_aresetn  asynchronous active-low reset
//     pixel        frame-buffer code {select, index}
//     DrawX/DrawY  current column/row
//     font_data    font-ROM row for the text region
//     vde          video data enable aligned with pixel
//     frame_start  one-cycle pulse at frame start
//     fade_cmd     00 none, 01 fade out, 10 fade in, 11 snap to full
//     fade_go      fade command strobe
//     pal_bus      palette write / readback bus (slave side)
//     Red/Green/Blue  colour outputs
//     vde_out      vde delayed to match RGB
//     fade_busy    high while a fade is in progress
module palette_engine #(
  parameter int SEL_W        = 5,
  parameter int IDX_W        = 3,
  parameter int COLOR_W      = 4,
  parameter int GAME_X_START = 160,
  parameter int GAME_X_END   = 479,
  parameter int TXT_X_END    = 159,
  parameter int TXT_Y_START  = 288,
  parameter int TXT_Y_END    = 479,
  parameter logic [3*COLOR_W-1:0] TXT_RGB = 12'h77A,
  parameter int FADE_FRAMES  = 2
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [SEL_W+IDX_W-1:0]   pixel,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [7:0]               font_data,
  input  logic                     vde,
  input  logic                     frame_start,
  input  logic [1:0]               fade_cmd,
  input  logic                     fade_go,
  palette_engine_if.slave          pal_bus,
  output logic [COLOR_W-1:0]       Red,
  output logic [COLOR_W-1:0]       Green,
  output logic [COLOR_W-1:0]       Blue,
  output logic                     vde_out,
  output logic                     fade_busy
);

  localparam int PIXEL_W = SEL_W + IDX_W;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int DEPTH   = 1 << PIXEL_W;
  localparam int CNT_W   = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);
  localparam logic [9:0] GXS = 10'(GAME_X_START);
  localparam logic [9:0] GXE = 10'(GAME_X_END);
  localparam logic [9:0] TXE = 10'(TXT_X_END);
  localparam logic [9:0] TYS = 10'(TXT_Y_START);
  localparam logic [9:0] TYE = 10'(TXT_Y_END);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_OUT  = 2'b01;
  localparam logic [1:0] CMD_IN   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_IN   = 2'd2
  } fade_state_t;

  // c * (lvl+1) / 16, truncated; level 15 is identity, level 0 is black
  function automatic logic [COLOR_W-1:0] fade_scale(input logic [COLOR_W-1:0] c,
                                                    input logic [3:0] lvl);
    logic [COLOR_W+3:0] prod;
    prod = (COLOR_W+4)'(c) * (COLOR_W+4)'({1'b0, lvl} + 5'd1);
    return COLOR_W'(prod >> 4);
  endfunction

  logic [RGB_W-1:0]   pal_ram [DEPTH];
  logic [RGB_W-1:0]   pal_rgb_p1;
  logic [9:0]         x_p1;
  logic [9:0]         y_p1;
  logic [7:0]         font_p1;
  logic               vld_p1;

  logic [RGB_W-1:0]   rgb_sel;
  logic [COLOR_W-1:0] red_p2;
  logic [COLOR_W-1:0] green_p2;
  logic [COLOR_W-1:0] blue_p2;
  logic               vld_p2;

  fade_state_t        fade_state;
  logic [3:0]         fade_lvl;
  logic [CNT_W-1:0]   frame_cnt;
  logic               fade_busy_q;

  // ---- stage 1: palette RAM write/read, register pixel context ----
  // Read uses the pre-write contents, so a same-address write this cycle
  // is only seen by the next pixel.
  always_ff @(posedge axi_aclk) begin
    if (pal_bus.pal_we) begin
      pal_ram[pal_bus.pal_waddr] <= pal_bus.pal_wdata;
    end
    pal_rgb_p1 <= pal_ram[pixel];
    x_p1       <= DrawX;
    y_p1       <= DrawY;
    font_p1    <= font_data;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vde;
    end
  end

  // ---- stage 2: region select, text overlay, fade, output register ----
  always_comb begin
    rgb_sel = '0;
    if (vld_p1) begin
      if ((x_p1 >= GXS) && (x_p1 <= GXE)) begin
        rgb_sel = pal_rgb_p1;
      end else if ((x_p1 <= TXE) && (y_p1 >= TYS) && (y_p1 <= TYE) &&
                   font_p1[3'd7 - x_p1[3:1]]) begin
        rgb_sel = TXT_RGB;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      red_p2   <= '0;
      green_p2 <= '0;
      blue_p2  <= '0;
      vld_p2   <= 1'b0;
    end else begin
      red_p2   <= fade_scale(rgb_sel[RGB_W-1 -: COLOR_W], fade_lvl);
      green_p2 <= fade_scale(rgb_sel[2*COLOR_W-1 -: COLOR_W], fade_lvl);
      blue_p2  <= fade_scale(rgb_sel[COLOR_W-1:0], fade_lvl);
      vld_p2   <= vld_p1;
    end
  end

  assign Red     = red_p2;
  assign Green   = green_p2;
  assign Blue    = blue_p2;
  assign vde_out = vld_p2;

  // ---- fade control: level only moves on frame_start, commands win ----
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      fade_state  <= ST_IDLE;
      fade_lvl    <= 4'hF;
      frame_cnt   <= '0;
      fade_busy_q <= 1'b0;
    end else if (fade_go && (fade_cmd != CMD_NONE)) begin
      frame_cnt <= '0;
      case (fade_cmd)
        CMD_OUT: begin
          fade_state  <= ST_OUT;
          fade_busy_q <= 1'b1;
        end
        CMD_IN: begin
          fade_state  <= ST_IN;
          fade_busy_q <= 1'b1;
        end
        default: begin
          fade_state  <= ST_IDLE;
          fade_lvl    <= 4'hF;
          fade_busy_q <= 1'b0;
        end
      endcase
    end else if (frame_start) begin
      case (fade_state)
        ST_OUT: begin
          if (fade_lvl == 4'h0) begin
            fade_state  <= ST_IDLE;
            fade_busy_q <= 1'b0;
            frame_cnt   <= '0;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            fade_lvl  <= fade_lvl - 4'd1;
            if (fade_lvl == 4'h1) begin
              fade_state  <= ST_IDLE;
              fade_busy_q <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        ST_IN: begin
          if (fade_lvl == 4'hF) begin
            fade_state  <= ST_IDLE;
            fade_busy_q <= 1'b0;
            frame_cnt   <= '0;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            fade_lvl  <= fade_lvl + 4'd1;
            if (fade_lvl == 4'hE) begin
              fade_state  <= ST_IDLE;
              fade_busy_q <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fade_busy = fade_busy_q;

`ifdef PALETTE_READBACK_EN
  logic [RGB_W-1:0] rb_data_p1;
  logic             rb_vld_p1;

  // ---- readback port: one-cycle registered read, pre-write contents ----
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rb_data_p1 <= '0;
      rb_vld_p1  <= 1'b0;
    end else begin
      rb_vld_p1 <= pal_bus.pal_rd;
      if (pal_bus.pal_rd) begin
        rb_data_p1 <= pal_ram[pal_bus.pal_raddr];
      end
    end
  end

  assign pal_bus.pal_rdata  = rb_data_p1;
  assign pal_bus.pal_rvalid = rb_vld_p1;
`else
  logic unused_rb;
  assign unused_rb          = ^{pal_bus.pal_raddr, pal_bus.pal_rd};
  assign pal_bus.pal_rdata  = '0;
  assign pal_bus.pal_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_palette_engine.sv
// tb_palette_engine
//   Randomised scoreboard bench for palette_engine. A behavioural model
//   (palette array, integer fade level/mode) predicts each visible pixel and
//   pushes it with its due cycle; a monitor on the falling edge pops and
//   compares whenever vde_out is high.
module tb_palette_engine;

  localparam int FADE_FRAMES = 2;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn = 1'b1;
  logic [7:0] pixel = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [7:0] font_data = '0;
  logic       vde = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] fade_cmd = '0;
  logic       fade_go = 1'b0;
  logic [3:0] Red, Green, Blue;
  logic       vde_out, fade_busy;

  palette_engine_if #(.SEL_W(5), .IDX_W(3), .COLOR_W(4)) bus ();

  palette_engine #(
    .SEL_W(5), .IDX_W(3), .COLOR_W(4),
    .GAME_X_START(160), .GAME_X_END(479), .TXT_X_END(159),
    .TXT_Y_START(288), .TXT_Y_END(479), .TXT_RGB(12'h77A),
    .FADE_FRAMES(FADE_FRAMES)
  ) dut (
    .axi_aclk(axi_aclk),
    .axi_aresetn(axi_aresetn),
    .pixel(pixel),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .font_data(font_data),
    .vde(vde),
    .frame_start(frame_start),
    .fade_cmd(fade_cmd),
    .fade_go(fade_go),
    .pal_bus(bus),
    .Red(Red),
    .Green(Green),
    .Blue(Blue),
    .vde_out(vde_out),
    .fade_busy(fade_busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] rgb;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [11:0] pal_m [256];
  int m_level, m_mode, m_cnt;     // m_mode: 0 idle, 1 fading out, 2 fading in
  logic        rb_pend;
  logic [11:0] rb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int scale(input int c);
    return (c * (m_level + 1)) / 16;
  endfunction

  task automatic model_reset();
    m_level = 15;
    m_mode  = 0;
    m_cnt   = 0;
    rb_pend = 1'b0;
    rb_exp  = '0;
  endtask

  // Applies the inputs of the current cycle to the model.
  task automatic model_step();
    int target;
    int xi, yi;
    logic [11:0] c;
    exp_t e;
    // fade control
    if (fade_go && fade_cmd != 2'd0) begin
      m_cnt = 0;
      if (fade_cmd == 2'd1) m_mode = 1;
      else if (fade_cmd == 2'd2) m_mode = 2;
      else begin
        m_mode  = 0;
        m_level = 15;
      end
    end else if (frame_start && m_mode != 0) begin
      target = (m_mode == 1) ? 0 : 15;
      if (m_level == target) begin
        m_mode = 0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
        if (m_cnt == FADE_FRAMES) begin
          m_cnt   = 0;
          m_level = m_level + ((m_mode == 1) ? -1 : 1);
          if (m_level == target) m_mode = 0;
        end
      end
    end
    // pixel colour (palette read sees contents before this cycle's write)
    if (vde) begin
      xi = int'(DrawX);
      yi = int'(DrawY);
      if (xi >= 160 && xi <= 479) c = pal_m[pixel];
      else if (xi <= 159 && yi >= 288 && yi <= 479 && font_data[7 - ((xi / 2) % 8)]) c = 12'h77A;
      else c = 12'h000;
      e.due = cyc + 2;
      e.rgb = {4'(scale(int'(c[11:8]))), 4'(scale(int'(c[7:4]))), 4'(scale(int'(c[3:0])))};
      sbq.push_back(e);
    end
    rb_pend = bus.pal_rd;
    if (bus.pal_rd) rb_exp = pal_m[bus.pal_raddr];
    if (bus.pal_we) pal_m[bus.pal_waddr] = bus.pal_wdata;
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    model_step();
    @(negedge axi_aclk);
    chk("fade_busy", {31'd0, fade_busy}, {31'd0, m_mode != 0});
`ifdef PALETTE_READBACK_EN
    chk("pal_rvalid", {31'd0, bus.pal_rvalid}, {31'd0, rb_pend});
    if (rb_pend) chk("pal_rdata", {20'd0, bus.pal_rdata}, {20'd0, rb_exp});
`else
    chk("pal_rvalid_off", {31'd0, bus.pal_rvalid}, 32'd0);
    chk("pal_rdata_off", {20'd0, bus.pal_rdata}, 32'd0);
`endif
    bus.pal_we  = 1'b0;
    bus.pal_rd  = 1'b0;
    fade_go     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      cycle();
      for (int j = 1; j < gap; j++) cycle();
    end
  endtask

  task automatic write_pal(input logic [7:0] a, input logic [11:0] d);
    bus.pal_we    = 1'b1;
    bus.pal_waddr = a;
    bus.pal_wdata = d;
  endtask

  task automatic fade(input logic [1:0] cmd);
    fade_go  = 1'b1;
    fade_cmd = cmd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rgb"}, {20'd0, Red, Green, Blue}, 32'd0);
    chk({tag, "_vde_out"}, {31'd0, vde_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, fade_busy}, 32'd0);
    chk({tag, "_rdata"}, {20'd0, bus.pal_rdata}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, bus.pal_rvalid}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge axi_aclk) begin
    if (axi_aresetn) begin
      if (vde_out) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got vde_out=1 expected no pixel (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rgb_latency", cyc, e.due);
          chk("rgb", {20'd0, Red, Green, Blue}, {20'd0, e.rgb});
        end
      end else begin
        chk("rgb_blank", {20'd0, Red, Green, Blue}, 32'd0);
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL vde_out_missing: got vde_out=0 expected 1 (cycle %0d)", cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pal_we = 1'b0; bus.pal_waddr = '0; bus.pal_wdata = '0;
    bus.pal_rd = 1'b0; bus.pal_raddr = '0;
    model_reset();
    #1 axi_aresetn = 1'b0;
    repeat (3) @(negedge axi_aclk);
    chk_all_zero("reset");
    axi_aresetn = 1'b1;

    // load every palette entry so the model knows all contents
    for (int i = 0; i < 256; i++) begin
      write_pal(8'(i), 12'($urandom));
      cycle();
    end

    // game window lookup after a write
    write_pal(8'h1A, 12'hF80);
    cycle();
    pixel = 8'h1A; DrawX = 10'd200; DrawY = 10'd10; vde = 1'b1;
    cycle();
    vde = 1'b0;
    cycle();
    chk("game_F80", {20'd0, Red, Green, Blue}, 32'hF80);
    chk("game_vde_out", {31'd0, vde_out}, 32'd1);
    cycle();
    chk("game_vde_out_drop", {31'd0, vde_out}, 32'd0);

    // text region
    DrawX = 10'd4; DrawY = 10'd300; font_data = 8'b0010_0000; vde = 1'b1;
    cycle();
    font_data = 8'h00;
    cycle();
    chk("text_77A", {20'd0, Red, Green, Blue}, 32'h77A);
    DrawX = 10'd480; font_data = 8'hFF;
    cycle();
    chk("text_off", {20'd0, Red, Green, Blue}, 32'h000);
    cycle();
    chk("outside_480", {20'd0, Red, Green, Blue}, 32'h000);

    // write/read collision on the same address
    write_pal(8'h05, 12'h321);
    vde = 1'b0;
    cycle();
    pixel = 8'h05; DrawX = 10'd300; vde = 1'b1;
    write_pal(8'h05, 12'h123);
    cycle();
    cycle();
    chk("collision_old", {20'd0, Red, Green, Blue}, 32'h321);
    cycle();
    chk("collision_new", {20'd0, Red, Green, Blue}, 32'h123);

    // randomised pixel stream with writes and readbacks
    for (int i = 0; i < 400; i++) begin
      pixel = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        DrawX = 10'($urandom_range(0, 159));
        DrawY = 10'($urandom_range(280, 490));
      end else begin
        DrawX = 10'($urandom_range(0, 639));
        DrawY = 10'($urandom_range(0, 524));
      end
      font_data = 8'($urandom);
      vde = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) write_pal(8'($urandom), 12'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        bus.pal_rd = 1'b1;
        bus.pal_raddr = 8'($urandom);
      end
      cycle();
    end

    // fade out / fade in on a white pixel
    vde = 1'b0;
    write_pal(8'h00, 12'hFFF);
    cycle();
    pixel = 8'h00; DrawX = 10'd200; vde = 1'b1;
    fade(2'b01);
    cycle();
    chk("fade_out_busy", {31'd0, fade_busy}, 32'd1);
    frames(2, 4);
    chk("fade_l14", {20'd0, Red, Green, Blue}, 32'hEEE);
    frames(28, 4);
    chk("fade_l0", {20'd0, Red, Green, Blue}, 32'h000);
    chk("fade_l0_idle", {31'd0, fade_busy}, 32'd0);
    fade(2'b10);
    cycle();
    frames(30, 4);
    chk("fade_in_full", {20'd0, Red, Green, Blue}, 32'hFFF);
    chk("fade_in_idle", {31'd0, fade_busy}, 32'd0);

    // override at level 9 together with frame_start
    fade(2'b01);
    cycle();
    frames(12, 4);
    chk("fade_l9", {20'd0, Red, Green, Blue}, 32'h999);
    fade(2'b11);
    frame_start = 1'b1;
    cycle();
    repeat (3) cycle();
    chk("snap_full", {20'd0, Red, Green, Blue}, 32'hFFF);
    chk("snap_idle", {31'd0, fade_busy}, 32'd0);

    // fade out requested while already at level 0
    fade(2'b01);
    cycle();
    frames(30, 4);
    fade(2'b01);
    cycle();
    chk("out_at_0_busy", {31'd0, fade_busy}, 32'd1);
    frames(1, 4);
    chk("out_at_0_idle", {31'd0, fade_busy}, 32'd0);
    chk("out_at_0_black", {20'd0, Red, Green, Blue}, 32'h000);
    fade(2'b11);
    cycle();
    repeat (3) cycle();

    // random fade commands, frames and pixels mixed
    for (int i = 0; i < 300; i++) begin
      pixel = 8'($urandom);
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 524));
      font_data = 8'($urandom);
      vde = ($urandom_range(0, 9) < 8);
      frame_start = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 24) == 0) fade(2'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) write_pal(8'($urandom), 12'($urandom));
      cycle();
    end

    // readback, including same-cycle write to the read address
    vde = 1'b0;
    write_pal(8'hFF, 12'hABC);
    cycle();
    bus.pal_rd = 1'b1; bus.pal_raddr = 8'hFF;
    cycle();
`ifdef PALETTE_READBACK_EN
    chk("rb_ABC", {20'd0, bus.pal_rdata}, 32'hABC);
    chk("rb_valid", {31'd0, bus.pal_rvalid}, 32'd1);
`endif
    write_pal(8'hFF, 12'h5A5);
    bus.pal_rd = 1'b1; bus.pal_raddr = 8'hFF;
    cycle();
`ifdef PALETTE_READBACK_EN
    chk("rb_collision_old", {20'd0, bus.pal_rdata}, 32'hABC);
`endif
    cycle();

    // reset in the middle of a fade
    write_pal(8'h00, 12'hFFF);
    cycle();
    pixel = 8'h00; DrawX = 10'd200; vde = 1'b1;
    fade(2'b01);
    cycle();
    frames(5, 4);
    axi_aresetn = 1'b0;
    #1;
    chk_all_zero("midfade_reset");
    sbq.delete();
    model_reset();
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    repeat (6) cycle();
    chk("post_reset_full", {20'd0, Red, Green, Blue}, 32'hFFF);
    chk("post_reset_idle", {31'd0, fade_busy}, 32'd0);

    vde = 1'b0;
    repeat (4) cycle();
    chk("sb_drain", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
